// File: rtl/addsub_rr_arbiter.sv
// Round-robin shared add/sub-accumulate unit with a private accumulator per requester.
// Latency: accept edge to rsp_valid is 1 cycle; a new grant is possible only after the response handshake (3 cycles minimum per op).
module addsub_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32,
   parameter int IDW   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ-1:0]       req_op,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   busy
);

   localparam int PW = IDW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic             op;
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } cmd_t;

   state_t           state, state_nxt;
   cmd_t             cmd_q;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_vld;
   logic [PW-1:0]    cand;
   logic [WIDTH-1:0] acc   [N_REQ];
   logic [WIDTH-1:0] a_arr [N_REQ];
   logic [WIDTH-1:0] b_arr [N_REQ];
   logic [WIDTH-1:0] res;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         a_arr[i] = req_a[i*WIDTH +: WIDTH];
         b_arr[i] = req_b[i*WIDTH +: WIDTH];
      end
   end

   // Search starts at rr_ptr and wraps; the first valid requester wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr} + PW'(k);
         if (cand >= PW'(N_REQ)) begin
            cand = cand - PW'(N_REQ);
         end
         if (!gnt_vld && req_valid[cand[IDW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Ready is gated by rst_n so nothing is offered while reset is held.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (rst_n && gnt_vld) begin
               req_ready[gnt_idx] = 1'b1;
               state_nxt          = EXEC;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign res  = cmd_q.op ? (cmd_q.a - cmd_q.b) : (cmd_q.a + cmd_q.b + acc[cmd_q.id]);
   assign busy = (state != IDLE);

   // rr_ptr advances only when the response is consumed, not at grant time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q     <= '0;
         rr_ptr    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            acc[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  cmd_q <= '{op: req_op[gnt_idx], id: gnt_idx, a: a_arr[gnt_idx], b: b_arr[gnt_idx]};
               end
            end
            EXEC: begin
               acc[cmd_q.id] <= res;
               rsp_data      <= res;
               rsp_id        <= cmd_q.id;
               rsp_valid     <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rr_ptr    <= (cmd_q.id == IDW'(N_REQ-1)) ? '0 : cmd_q.id + IDW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed bench for addsub_rr_arbiter: stimulus pushes expected responses, a monitor pops them on each handshake.
module tb_addsub_rr_arbiter;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   req_op;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [W-1:0]   rsp_data;
   logic           busy;

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   data;
   } exp_t;

   exp_t       exp_q[$];
   int         total = 0;
   int         bad   = 0;
   int         wt;
   logic       r2_vld [N];
   logic       r2_op  [N];
   logic [W-1:0] r2_a [N];
   logic [W-1:0] r2_b [N];

   addsub_rr_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      req_op[i]       = op;
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic expect_rsp(input int i, input logic [W-1:0] d);
      exp_t e;
      e.id   = IDW'(i);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Called just after a rising edge; returns just after the accept edge (DUT in EXEC).
   task automatic issue(input int i, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, output int waited);
      set_req(i, op, a, b);
      req_valid[i] = 1'b1;
      expect_rsp(i, exp);
      waited = 0;
      @(negedge clk);
      while (!req_ready[i] && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!req_ready[i]) begin
         total++;
         bad++;
         $display("FAIL grant_timeout: got no ready for req%0d expected ready", i);
      end
      @(posedge clk);
      #2;
      req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      @(posedge clk);
      #2;
   endtask

   // Requesters held valid; expects grants 0,1,2,3,... one every 3 cycles.
   task automatic grant_loop(input int n, input string tag);
      int   ng   = 0;
      int   last = 0;
      int   gi   = 0;
      logic got;
      for (int c = 0; c < 120 && ng < n; c++) begin
         @(negedge clk);
         got = 1'b0;
         if (req_ready != '0) begin
            chk({tag, "_onehot"}, W'($onehot(req_ready)), W'(1));
            for (int j = 0; j < N; j++) begin
               if (req_ready[j]) gi = j;
            end
            chk({tag, "_order"}, W'(gi), W'(ng % N));
            if (ng > 0) chk({tag, "_spacing"}, W'(c - last), W'(3));
            last = c;
            ng++;
            got  = 1'b1;
         end
         @(posedge clk);
         #2;
         if (got) begin
            if (r2_vld[gi]) begin
               set_req(gi, r2_op[gi], r2_a[gi], r2_b[gi]);
               r2_vld[gi] = 1'b0;
            end else begin
               req_valid[gi] = 1'b0;
            end
         end
      end
      total++;
      if (ng < n) begin
         bad++;
         $display("FAIL %s_timeout: got %0d grants expected %0d", tag, ng, n);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got id=%0d data=%0h expected none", rsp_id, rsp_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_id", W'(rsp_id), W'(e.id));
            chk("sb_data", rsp_data, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '1;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < N; i++) begin
         r2_vld[i] = 1'b0;
         r2_op[i]  = 1'b0;
         r2_a[i]   = '0;
         r2_b[i]   = '0;
      end

      // Reset state, with every requester asking
      @(negedge clk);
      chk("rst_rsp_valid", W'(rsp_valid), W'(0));
      chk("rst_rsp_id", W'(rsp_id), W'(0));
      chk("rst_rsp_data", rsp_data, W'(0));
      chk("rst_req_ready", W'(req_ready), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      @(posedge clk);
      #2;
      req_valid = '0;
      rst_n     = 1'b1;

      // 1: ADD-ACC on req0 and its timing
      issue(0, 1'b0, 32'd5, 32'd3, 32'd8, wt);
      chk("t1_grant_cycle", W'(wt), W'(0));
      @(negedge clk);
      chk("t1_exec_rsp_valid", W'(rsp_valid), W'(0));
      chk("t1_exec_busy", W'(busy), W'(1));
      @(negedge clk);
      chk("t1_resp_rsp_valid", W'(rsp_valid), W'(1));
      @(posedge clk);
      #2;
      drain();
      issue(0, 1'b0, 32'd1, 32'd1, 32'd10, wt);
      drain();

      // 2: SUB wrap then accumulate wrap on req1
      issue(1, 1'b1, 32'd1, 32'd2, 32'hFFFF_FFFF, wt);
      drain();
      issue(1, 1'b0, 32'd0, 32'd1, 32'd0, wt);
      drain();
      issue(3, 1'b1, 32'd0, 32'd0, 32'd0, wt);
      drain();

      // 3: all four held valid, two rounds
      set_req(0, 1'b0, 32'd1, 32'd1);
      set_req(1, 1'b0, 32'd2, 32'd0);
      set_req(2, 1'b0, 32'd3, 32'd0);
      set_req(3, 1'b1, 32'd10, 32'd4);
      r2_vld = '{1'b1, 1'b1, 1'b1, 1'b1};
      r2_op  = '{1'b1, 1'b0, 1'b0, 1'b0};
      r2_a   = '{32'd5, 32'd1, 32'd10, 32'd0};
      r2_b   = '{32'd6, 32'd1, 32'd0, 32'd0};
      expect_rsp(0, 32'd12);
      expect_rsp(1, 32'd2);
      expect_rsp(2, 32'd3);
      expect_rsp(3, 32'd6);
      expect_rsp(0, 32'hFFFF_FFFF);
      expect_rsp(1, 32'd4);
      expect_rsp(2, 32'd13);
      expect_rsp(3, 32'd6);
      req_valid = '1;
      grant_loop(8, "t3");
      drain();

      // 4: response stall holds outputs and blocks new grants
      rsp_ready = 1'b0;
      issue(1, 1'b0, 32'd5, 32'd5, 32'd14, wt);
      set_req(2, 1'b0, 32'd2, 32'd0);
      req_valid[2] = 1'b1;
      expect_rsp(2, 32'd15);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t4_rsp_valid", W'(rsp_valid), W'(1));
         chk("t4_rsp_data", rsp_data, W'(14));
         chk("t4_rsp_id", W'(rsp_id), W'(1));
         chk("t4_busy", W'(busy), W'(1));
         chk("t4_req_ready", W'(req_ready), W'(0));
      end
      @(posedge clk);
      #2;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #2;
      @(negedge clk);
      chk("t4_release_rsp_valid", W'(rsp_valid), W'(0));
      chk("t4_release_busy", W'(busy), W'(0));
      chk("t4_next_grant", W'(req_ready), W'(4'b0100));
      @(posedge clk);
      #2;
      req_valid[2] = 1'b0;
      drain();

      // 5: context isolation between req2 and req3
      issue(2, 1'b0, 32'd40, 32'd45, 32'd100, wt);
      drain();
      issue(3, 1'b1, 32'd0, 32'd0, 32'd0, wt);
      drain();
      issue(3, 1'b0, 32'd7, 32'd0, 32'd7, wt);
      drain();
      issue(2, 1'b0, 32'd0, 32'd0, 32'd100, wt);
      drain();

      // 6: reset while an op is in EXEC
      issue(1, 1'b0, 32'd0, 32'd0, 32'd14, wt);
      drain();
      issue(2, 1'b0, 32'd1, 32'd1, 32'd102, wt);
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'd1, 32'd0);
      req_valid = '1;
      rst_n     = 1'b0;
      #1;
      chk("t6_rst_busy", W'(busy), W'(0));
      chk("t6_rst_rsp_valid", W'(rsp_valid), W'(0));
      chk("t6_rst_req_ready", W'(req_ready), W'(0));
      exp_q.delete();
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) expect_rsp(i, 32'd1);
      grant_loop(4, "t6");
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
